pulse_generator: RTL
====================

# pulse_generator

Programmable one-shot pulse generator built on a loadable down-counter; the producing counterpart to the free-running up-counter used to measure pulse widths. On a start request it drives `Pulse` high for a programmed number of clock cycles, then enforces a programmed hold-off before it accepts the next request. The sensor front end uses it to fire ultrasonic trigger pulses whose echo is then timed by the measuring counter.

## Interface
- `bits`, 14, width of `Width`, `Holdoff` and the internal down-counter.
- `Clock`  input  1  system clock, rising edge.
- `Reset`  input  1  asynchronous, active-high reset.
- `Start`  input  1  request a pulse; sampled only when `Busy`=0.
- `Width`  input  bits  pulse length in cycles, latched on accepted `Start`.
- `Holdoff`  input  bits  low time after the pulse in cycles, latched on accepted `Start`.
- `Repeat`  input  1  auto-restart request; present only with `PULSE_GEN_REPEAT_EN`.
- `Pulse`  output  1  generated pulse, registered.
- `Busy`  output  1  high from the first pulse cycle through the last hold-off cycle, registered.
- `Done`  output  1  one-cycle strobe at the completion of each sequence, registered.

## Operation
- States: IDLE, PULSE, HOLDOFF. One `bits`-wide down-counter `cnt`, plus latched `w_q` and `h_q`.
- IDLE: `Pulse`=0, `Busy`=0. `Start`=1 with `Width`≠0: latch `Width`/`Holdoff`, load `cnt`=`Width`-1, go to PULSE. `Start` with `Width`=0 is ignored: stay in IDLE, no `Done`.
- PULSE: `Pulse`=1, `Busy`=1, `cnt` decrements each cycle. When `cnt`=0: if `h_q`≠0, load `cnt`=`h_q`-1 and go to HOLDOFF; otherwise the sequence ends.
- HOLDOFF: `Pulse`=0, `Busy`=1, `cnt` decrements. When `cnt`=0 the sequence ends.
- Sequence end: `Done`=1 for exactly one cycle, go to IDLE. With `PULSE_GEN_REPEAT_EN`, see Configuration.
- `Start` while `Busy`=1 is ignored and is not queued. Input changes on `Width`/`Holdoff` during a sequence have no effect.
- Counter never wraps. Loads are always ≥0 and the counter only decrements while nonzero or at a terminal transition.
- Max pulse is 2^bits-1 cycles (16383 at default). Max hold-off is the same.
- Reset (asynchronous, any state): state=IDLE, `cnt`=0, `w_q`=`h_q`=0, `Pulse`=0, `Busy`=0, `Done`=0 immediately. An in-flight pulse is truncated and no `Done` is issued.

## Timing
- `Start` accepted at edge k gives `Pulse`=1 in cycles k+1 … k+W and `Busy`=1 in cycles k+1 … k+W+H.
- `Done`=1 in cycle k+W+H+1, which is also the first cycle with `Busy`=0.
- A `Start` sampled at the edge ending the `Done` cycle is accepted. The minimum start-to-start period is therefore W+H+1 cycles.
- H=0: `Busy` falls and `Done` rises in cycle k+W+1.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `PULSE_GEN_REPEAT_EN` defined:
  - The `Repeat` port exists.
  - `Repeat` is sampled in the final cycle of a sequence: the last HOLDOFF cycle, or the last PULSE cycle when `h_q`=0.
  - If `Repeat`=1, the block reloads `cnt`=`w_q`-1 and goes directly to PULSE with no IDLE cycle. The period is exactly W+H cycles, using the latched values.
  - `Done` still pulses for one cycle per completed sequence, coincident with the first `Pulse` cycle of the next sequence. `Busy` stays high.
  - If `Repeat`=0, behaviour is as in Operation.
- Not defined:
  - The `Repeat` port is absent.
  - Every sequence returns to IDLE.

## Test plan
- Basic: W=3, H=2, `Start` at edge 10 -> `Pulse` high cycles 11–13, `Busy` 11–15, `Done` only in cycle 16.
- Ignore-while-busy: W=5, H=5, `Start` at 10, a second `Start` at 13 -> one pulse only; `Done` only at 21; no second `Pulse`.
- Back-to-back plus zero hold-off: W=2, H=0, `Start` held high -> `Pulse` 11–12, `Done` 13, `Pulse` 14–15, `Done` 16.
- Zero width: W=0, `Start` at 10 -> `Pulse`, `Busy` and `Done` stay 0 for 20 cycles.
- Reset mid-pulse: W=100, `Start` at 10, `Reset` asserted asynchronously mid-cycle 40 -> `Pulse`=`Busy`=0 before the next edge, no `Done`. After release, `Start` with W=1 gives `Pulse` for exactly one cycle.
- Repeat (macro defined): W=3, H=1, `Repeat`=1 -> `Pulse` rising edges every 4 cycles and `Done` coincident with each restart. Dropping `Repeat` lets the current sequence finish, then IDLE.

Source files
------------

// File: rtl/pulse_generator_if.sv
// Signal bundle between a pulse_generator and whatever requests pulses from it.
// The Repeat line exists only when PULSE_GEN_REPEAT_EN is defined.
interface pulse_generator_if #(
  parameter int BITS = 14
) ();
  // Start is a level request: it is taken on any rising Clock edge where the
  // generator is idle (Busy=0) and Width is nonzero; otherwise it is dropped, never queued.
  logic            Start;
  logic [BITS-1:0] Width;
  logic [BITS-1:0] Holdoff;
`ifdef PULSE_GEN_REPEAT_EN
  logic            Repeat;
`endif
  logic            Pulse;
  logic            Busy;
  logic            Done;

`ifdef PULSE_GEN_REPEAT_EN
  modport master (output Start, Width, Holdoff, Repeat, input Pulse, Busy, Done);
  modport slave  (input Start, Width, Holdoff, Repeat, output Pulse, Busy, Done);
`else
  modport master (output Start, Width, Holdoff, input Pulse, Busy, Done);
  modport slave  (input Start, Width, Holdoff, output Pulse, Busy, Done);
`endif
endinterface

// File: rtl/pulse_generator.sv
// One-shot pulse generator: Pulse for Width cycles, then Holdoff busy cycles, then a Done strobe.
// Optional auto-restart is compiled in with PULSE_GEN_REPEAT_EN.
module pulse_generator #(
  parameter int BITS = 14
) (
  input  logic             Clock,
  input  logic             Reset,
  pulse_generator_if.slave bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic [BITS-1:0] w_q, w_d;
  logic [BITS-1:0] h_q, h_d;
  logic            pulse_q, pulse_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            seq_end;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      h_q     <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      h_q     <= h_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    h_d     = h_q;
    done_d  = 1'b0;
    seq_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start && (bus.Width != '0)) begin
          w_d     = bus.Width;
          h_d     = bus.Holdoff;
          cnt_d   = bus.Width - ONE;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (h_q != '0) begin
            cnt_d   = h_q - ONE;
            state_d = HOLDOFF;
          end else begin
            seq_end = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          seq_end = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sequence end: the strobe lands in the cycle after the last busy cycle.
    if (seq_end) begin
      done_d = 1'b1;
`ifdef PULSE_GEN_REPEAT_EN
      if (bus.Repeat) begin
        cnt_d   = w_q - ONE;
        state_d = PULSE;
      end else begin
        state_d = IDLE;
      end
`else
      state_d = IDLE;
`endif
    end

    // Outputs are registered copies of the next state, so they change on the edge itself.
    pulse_d = (state_d == PULSE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.Pulse   = pulse_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign dbg_state_o = state_q;

endmodule
